// File: rtl/gray_ptr_receiver.sv
// gray_ptr_receiver: read-side pointer logic for a gray-pointer FIFO.
// Synchronizes the write side's gray pointer, keeps the read pointer in
// binary and gray form, and registers empty, fill level and a sticky
// underflow flag. Status is computed from next-state values so it moves
// on the same edge as the pointers.
module gray_ptr_receiver #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pop,
    input  logic [N-1:0] wptr,
    output logic [N-2:0] adr,
    output logic [N-1:0] ptr,
    output logic         empty,
    output logic [N-1:0] level,
    output logic         underflow
);

    logic [N-1:0] sync1_q, sync2_q;
    logic [N-1:0] rbin_q,  rbin_d;
    logic [N-1:0] ptr_q,   ptr_d;
    logic [N-1:0] level_q, level_d;
    logic         empty_q, empty_d;
    logic         underflow_q, underflow_d;
    logic [N-1:0] wbin_d;
    logic         acc;

    // Gray to binary: bit i is the XOR of gray bits i through N-1.
    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int unsigned i = 1; i < N; i++) begin
            b[N-1-i] = b[N-i] ^ g[N-1-i];
        end
        return b;
    endfunction

    // Next-state logic for the read pointer and status flags.
    always_comb begin
        acc         = pop & ~empty_q;
        rbin_d      = rbin_q + {{(N-1){1'b0}}, acc};
        ptr_d       = rbin_d ^ (rbin_d >> 1);
        // sync1 is the value sync2 takes at this edge, so status tracks sync2.
        wbin_d      = g2b(sync1_q);
        level_d     = wbin_d - rbin_d;
        empty_d     = (sync1_q == ptr_d);
        underflow_d = underflow_q | (pop & empty_q);
    end

    // State registers with synchronous reset; reset overrides pop and wptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            rbin_q      <= '0;
            ptr_q       <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            sync1_q     <= wptr;
            sync2_q     <= sync1_q;
            rbin_q      <= rbin_d;
            ptr_q       <= ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    // Registered status must always agree with the second synchronizer stage.
    a_level_consistent : assert property (@(posedge clk) disable iff (rst)
        level_q == (g2b(sync2_q) - rbin_q));
    a_empty_consistent : assert property (@(posedge clk) disable iff (rst)
        empty_q == (sync2_q == ptr_q));

    assign adr       = rbin_q[N-2:0];
    assign ptr       = ptr_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Directed self-checking bench for gray_ptr_receiver (N = 4, depth 8).
module tb_gray_ptr_receiver;

    logic       clk;
    logic       rst;
    logic       pop;
    logic [3:0] wptr;
    logic [2:0] adr;
    logic [3:0] ptr;
    logic       empty;
    logic [3:0] level;
    logic       underflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    gray_ptr_receiver #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pop       (pop),
        .wptr      (wptr),
        .adr       (adr),
        .ptr       (ptr),
        .empty     (empty),
        .level     (level),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input int unsigned v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    logic [3:0]  prev_ptr;
    int unsigned exp_rb;

    initial begin
        rst = 1'b1; pop = 1'b0; wptr = 4'b0000;

        // Reset: two edges, then hold with wptr at 0.
        tick; tick;
        check("rst_ptr",   ptr,       4'b0000);
        check("rst_adr",   adr,       3'b000);
        check("rst_empty", empty,     1'b1);
        check("rst_level", level,     4'd0);
        check("rst_uf",    underflow, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle_ptr",   ptr,   4'b0000);
            check("idle_empty", empty, 1'b1);
            check("idle_level", level, 4'd0);
        end

        // Single write then pop.
        wptr = 4'b0001;
        tick;
        check("sw_empty_k",  empty, 1'b1);
        check("sw_level_k",  level, 4'd0);
        tick;
        check("sw_empty_k1", empty, 1'b0);
        check("sw_level_k1", level, 4'd1);
        pop = 1'b1;
        tick;
        pop = 1'b0;
        check("sw_pop_ptr",   ptr,   4'b0001);
        check("sw_pop_adr",   adr,   3'b001);
        check("sw_pop_empty", empty, 1'b1);
        check("sw_pop_level", level, 4'd0);

        // Fill to full from reset: level lags the wptr step by one edge.
        rst = 1'b1; wptr = 4'b0000;
        tick;
        rst = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            wptr = gray4(i);
            tick;
            check("fill_level", level, i - 1);
        end
        check("fill_last_wptr", wptr, 4'b1100);
        tick;
        check("full_level", level, 4'd8);
        check("full_empty", empty, 1'b0);

        // Wrap-around: write and pop every cycle with 4 entries banked.
        rst = 1'b1; wptr = 4'b0000;
        tick;
        rst = 1'b0;
        wptr = gray4(4);
        tick; tick;
        check("wrap_pre_level", level, 4'd4);
        exp_rb   = 0;
        prev_ptr = 4'b0000;
        for (int unsigned j = 1; j <= 64; j++) begin
            wptr = gray4((4 + j) % 16);
            pop  = 1'b1;
            tick;
            exp_rb = (exp_rb + 1) % 16;
            check("wrap_ptr",   ptr, gray4(exp_rb));
            check("wrap_adr",   adr, exp_rb % 8);
            check("wrap_1bit",  $countones(ptr ^ prev_ptr), 1);
            check("wrap_level", level, 4'd3);
            check("wrap_empty", empty, 1'b0);
            prev_ptr = ptr;
        end
        pop = 1'b0;
        tick;
        check("wrap_post_level", level, 4'd4);
        check("wrap_post_ptr",   ptr,   4'b0000);

        // Drain the 4 entries, then underflow with pop held for 3 cycles.
        pop = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        check("drain_empty", empty,     1'b1);
        check("drain_level", level,     4'd0);
        check("drain_ptr",   ptr,       4'b0110);
        check("drain_adr",   adr,       3'b100);
        check("drain_uf",    underflow, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("uf_ptr",   ptr,       4'b0110);
            check("uf_adr",   adr,       3'b100);
            check("uf_level", level,     4'd0);
            check("uf_flag",  underflow, 1'b1);
        end
        pop = 1'b0;
        tick;
        check("uf_sticky", underflow, 1'b1);
        check("uf_ptr2",   ptr,       4'b0110);

        // Bring level to 3, then pop on the edge where the new write lands.
        wptr = gray4(5); tick;
        wptr = gray4(6); tick;
        wptr = gray4(7); tick;
        tick;
        check("sim_pre_level", level, 4'd3);
        check("sim_pre_empty", empty, 1'b0);
        wptr = gray4(8);
        tick;
        check("sim_sync_level", level, 4'd3);
        pop = 1'b1;
        tick;
        pop = 1'b0;
        check("sim_level", level, 4'd3);
        check("sim_empty", empty, 1'b0);
        check("sim_ptr",   ptr,   4'b0111);
        check("sim_adr",   adr,   3'b101);

        // Reset mid-stream overrides pop and an in-flight wptr change.
        pop = 1'b1; wptr = gray4(9); rst = 1'b1;
        tick;
        check("mrst_ptr",   ptr,       4'b0000);
        check("mrst_adr",   adr,       3'b000);
        check("mrst_empty", empty,     1'b1);
        check("mrst_level", level,     4'd0);
        check("mrst_uf",    underflow, 1'b0);
        rst = 1'b0; pop = 1'b0; wptr = 4'b0000;
        tick;
        check("post_ptr",   ptr,       4'b0000);
        check("post_empty", empty,     1'b1);
        check("post_level", level,     4'd0);
        check("post_uf",    underflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
